pio_led_ctrl: RTL and testbench

LED pattern engine downstream of the host-writable 8-bit PIO in the Qsys system. It takes the PIO export value written over the PCIe interface and drives `leds[7:0]` in one of four display modes: static, blink, chase or PWM dim. The heartbeat LED `leds[8]` stays outside this block. It runs on the 100 MHz board clock, the same clock as the Qsys `clk_100` domain, so no synchronisers are needed.

---
 rtl/pio_led_ctrl.sv | 118 +++++++++++
 tb/tb_pio_led_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pio_led_ctrl.sv
// pio_led_ctrl: LED pattern engine (static / blink / chase / PWM dim) driven by the host PIO export.
// Build option: define PIO_LED_PWM_EN to make mode 11 a PWM dimmer; otherwise mode 11 decodes as static.
module pio_led_ctrl #(
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned PWM_BITS = 6
) (
   input  logic       clk_u59,
   input  logic       rst_n,
   input  logic [7:0] pio_value,
   output logic [7:0] leds,
   output logic       mode_chg
);

   // mode | meaning
   // 00   | STATIC: pattern bits shown directly
   // 01   | BLINK : pattern toggles on/off every tick
   // 10   | CHASE : single lit LED walks 0..7 every tick
   // 11   | PWM   : all LEDs dimmed by duty (static when PWM is not built)
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_PWM    = 2'b11
   } mode_e;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

   logic [7:0]          pio_q;
   logic [7:0]          pio_prev;
   logic [31:0]         tick_cnt;
   logic                phase;
   logic [2:0]          pos;
   logic                chg;
   logic                tick;
   mode_e               mode;
   logic [PWM_BITS-1:0] pat;
   logic [7:0]          leds_static;
   logic                phase_eff;
   logic [2:0]          pos_eff;
   logic [7:0]          leds_nxt;

   assign chg         = (pio_q != pio_prev);
   assign tick        = (tick_cnt == TICK_LAST) && !chg;
   assign mode        = mode_e'(pio_q[7:6]);
   assign pat         = pio_q[PWM_BITS-1:0];
   assign leds_static = {{(8 - PWM_BITS){1'b0}}, pat};

   // On a change the new mode is shown at once, using the values the counters are cleared to.
   assign phase_eff = chg | phase;
   assign pos_eff   = chg ? 3'd0 : pos;

`ifdef PIO_LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] pwm_eff;
   logic                pwm_on;

   assign pwm_eff = chg ? '0 : pwm_cnt;
   assign pwm_on  = (pwm_eff < pat);

   always_ff @(posedge clk_u59) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (chg) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      leds_nxt = leds_static;
      case (mode)
         MODE_BLINK: leds_nxt = phase_eff ? leds_static : 8'h00;
         MODE_CHASE: leds_nxt = 8'h01 << pos_eff;
`ifdef PIO_LED_PWM_EN
         MODE_PWM:   leds_nxt = pwm_on ? 8'hFF : 8'h00;
`endif
         default:    leds_nxt = leds_static;
      endcase
   end

   always_ff @(posedge clk_u59) begin
      if (!rst_n) begin
         pio_q    <= 8'h00;
         pio_prev <= 8'h00;
         tick_cnt <= '0;
         phase    <= 1'b1;
         pos      <= 3'd0;
         leds     <= 8'h00;
         mode_chg <= 1'b0;
      end else begin
         pio_q    <= pio_value;
         pio_prev <= pio_q;
         leds     <= leds_nxt;
         mode_chg <= chg;

         if (chg || tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 32'd1;
         end

         if (chg) begin
            phase <= 1'b1;
         end else if (tick && mode == MODE_BLINK) begin
            phase <= ~phase;
         end

         if (chg) begin
            pos <= 3'd0;
         end else if (tick && mode == MODE_CHASE) begin
            pos <= pos + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_pio_led_ctrl.sv
// Self-checking bench for pio_led_ctrl (TICK_DIV=4); expected LED/mode_chg values queued per clock.
module tb_pio_led_ctrl;

   logic       clk_u59 = 1'b0;
   logic       rst_n   = 1'b0;
   logic [7:0] pio_value = 8'hFF;
   logic [7:0] leds;
   logic       mode_chg;

   pio_led_ctrl #(.TICK_DIV(4), .PWM_BITS(6)) dut (
      .clk_u59   (clk_u59),
      .rst_n     (rst_n),
      .pio_value (pio_value),
      .leds      (leds),
      .mode_chg  (mode_chg)
   );

   always #5 clk_u59 = ~clk_u59;

   int unsigned cyc = 0;
   always @(posedge clk_u59) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      logic [7:0]  leds;
      logic        mc;
      bit          chk_leds;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int unsigned last_c = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic push(input int unsigned at, input logic [7:0] l, input logic mc,
                       input bit cl, input string tag);
      exp_t e;
      e.at = at; e.leds = l; e.mc = mc; e.chk_leds = cl; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_u59);
         #1;
      end
   endtask

   // Expected LEDs i clocks after the edge where mode_chg pulses for value v.
   function automatic logic [7:0] pat(input logic [7:0] v, input int i);
      logic [7:0] one;
      logic [7:0] stat;
      int         p;
      int         cnt;
      one  = 8'h01;
      stat = {2'b00, v[5:0]};
      case (v[7:6])
         2'b01: return (i <= 4 || ((i - 5) / 4) % 2 == 1) ? stat : 8'h00;
         2'b10: begin
            p = (i <= 4) ? 0 : (1 + (i - 5) / 4) % 8;
            return one << p;
         end
         2'b11: begin
`ifdef PIO_LED_PWM_EN
            cnt = (i == 0) ? 0 : (i - 1) % 64;
            return (cnt < int'(v[5:0])) ? 8'hFF : 8'h00;
`else
            cnt = 0;
            return stat;
`endif
         end
         default: return stat;
      endcase
   endfunction

   // Drive v now and queue n clocks of expectations; new_val marks a real change.
   task automatic apply(input logic [7:0] v, input int n, input bit new_val, input string tag);
      int unsigned p;
      int unsigned at;
      p = cyc;
      pio_value = v;
      if (new_val) last_c = p + 2;
      for (int i = 1; i <= n; i++) begin
         at = p + i;
         if (new_val && at == p + 1) push(at, 8'h00, 1'b0, 1'b0, tag);
         else push(at, pat(v, int'(at) - int'(last_c)), (at == last_c), 1'b1, tag);
      end
      step(n);
   endtask

   always @(negedge clk_u59) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at < cyc) check({e.tag, ".stale"}, e.at, cyc);
         else begin
            if (e.chk_leds) check({e.tag, ".leds"}, leds, e.leds);
            check({e.tag, ".mode_chg"}, mode_chg, e.mc);
         end
      end
   end

   initial begin
      int unsigned base;
      int          guard;

      // Reset held 3 clocks with 0xFF presented.
      for (int i = 1; i <= 3; i++) push(i, 8'h00, 1'b0, 1'b1, "rst");
      step(3);
      rst_n = 1'b1;
      push(cyc + 1, 8'h00, 1'b0, 1'b1, "rst_rel0");
      apply(8'hFF, 70, 1'b1, "rst_rel");

      apply(8'h2A, 8, 1'b1, "static");
      apply(8'h2A, 6, 1'b0, "rewrite");

      apply(8'h55, 16, 1'b1, "blink");
      apply(8'h56, 14, 1'b1, "blink_restart");

      apply(8'h80, 40, 1'b1, "chase");

      // Back-to-back changes: each restarts the chase at LED 0.
      base = cyc;
      push(base + 1, 8'h00, 1'b0, 1'b0, "b2b");
      push(base + 2, 8'h01, 1'b1, 1'b1, "b2b");
      push(base + 3, 8'h01, 1'b1, 1'b1, "b2b");
      push(base + 4, 8'h01, 1'b1, 1'b1, "b2b");
      pio_value = 8'h81;
      step(1);
      pio_value = 8'h82;
      step(1);
      pio_value = 8'h83;
      step(2);
      last_c = base + 4;
      apply(8'h83, 16, 1'b0, "b2b_run");

      apply(8'hD0, 140, 1'b1, "pwm16");
      apply(8'hC0, 70, 1'b1, "pwm0");

      // Reset mid-chase while position 5 is lit.
      apply(8'h80, 24, 1'b1, "chase_pre");
      rst_n = 1'b0;
      push(cyc + 1, 8'h00, 1'b0, 1'b1, "rst_mid");
      push(cyc + 2, 8'h00, 1'b0, 1'b1, "rst_mid");
      step(2);
      rst_n = 1'b1;
      push(cyc + 1, 8'h00, 1'b0, 1'b1, "rst_mid_rel");
      apply(8'h80, 20, 1'b1, "chase_post");

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         step(1);
         guard++;
      end
      check("drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
